// File: rtl/jtcps1_obj_line_table.sv
// Per-scanline object scanner: walks the 256-entry OBJ table, keeps objects that cross
// the requested line and expands them into one ping-pong line-list entry per 16-pixel tile.
module jtcps1_obj_line_table #(
    parameter int MAXT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8:0]               vrender,
    output logic [9:0]               table_addr,
    input  logic [15:0]              table_data,
    output logic                     busy,
    input  logic [$clog2(MAXT)+2:0]  buf_addr,
    output logic [15:0]              buf_data
);

    localparam int LW    = $clog2(MAXT);
    localparam int AW    = LW + 3;
    localparam int DEPTH = 1 << AW;

    // CHECK and NEXT are resolved on the clock that samples Y / finishes the last tile,
    // so an invisible entry costs exactly its two table reads.
    typedef enum logic [3:0] {
        IDLE, INIT, RD_ATTR, RD_Y, RD_X, RD_CODE, EMIT, TERM, ABORT
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    entry_q, entry_d;
    logic [4:0]    pal_q, pal_d;
    logic          hflip_q, hflip_d;
    logic          vflip_q, vflip_d;
    logic [3:0]    nx_q, nx_d;
    logic [3:0]    ny_q, ny_d;
    logic [7:0]    dy_q, dy_d;
    logic [8:0]    x_q, x_d;
    logic [15:0]   code_q, code_d;
    logic [3:0]    tile_q, tile_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [LW:0]   wr_ptr_q, wr_ptr_d;
    logic          bank_q, bank_d;
    logic [8:0]    vrender_q, vrender_d;
    logic          busy_q, busy_d;
    logic [9:0]    table_addr_q, table_addr_d;
    logic [15:0]   buf_data_q, buf_data_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    logic [8:0]    dy_new;
    logic          visible;
    logic          advance;
    logic [3:0]    row;
    logic [3:0]    col;
    logic [3:0]    vsub;
    logic [8:0]    tile_x;
    logic [15:0]   tile_code;

    logic [15:0]   list_mem [DEPTH];

    assign table_addr = table_addr_q;
    assign busy       = busy_q;
    assign buf_data   = buf_data_q;

    // Tile expansion: row/column fields wrap independently inside the code.
    always_comb begin
        row       = vflip_q ? (ny_q - dy_q[7:4]) : dy_q[7:4];
        col       = hflip_q ? (nx_q - tile_q) : tile_q;
        tile_code = {code_q[15:4] + {8'd0, row}, code_q[3:0] + col};
        vsub      = dy_q[3:0] ^ {4{vflip_q}};
        tile_x    = x_q + {1'b0, tile_q, 4'b0000};
        dy_new    = vrender_q - table_data[8:0];
        visible   = {1'b0, dy_new} < ({2'b00, ny_q, 4'b0000} + 10'd16);
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        entry_d      = entry_q;
        pal_d        = pal_q;
        hflip_d      = hflip_q;
        vflip_d      = vflip_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        dy_d         = dy_q;
        x_d          = x_q;
        code_d       = code_q;
        tile_d       = tile_q;
        wcnt_d       = wcnt_q;
        wr_ptr_d     = wr_ptr_q;
        bank_d       = bank_q;
        vrender_d    = vrender_q;
        table_addr_d = table_addr_q;
        advance      = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = {bank_q, wr_ptr_q[LW-1:0], wcnt_q};
        mem_wdata    = 16'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vrender_d = vrender;
                    bank_d    = vrender[0];
                    wr_ptr_d  = '0;
                    state_d   = INIT;
                end
            end
            INIT: begin
                entry_d      = 8'hFF;
                table_addr_d = {8'hFF, 2'd3};
                phase_d      = 1'b0;
                state_d      = RD_ATTR;
            end
            RD_ATTR: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    pal_d        = table_data[4:0];
                    hflip_d      = table_data[5];
                    vflip_d      = table_data[6];
                    nx_d         = table_data[11:8];
                    ny_d         = table_data[15:12];
                    table_addr_d = {entry_q, 2'd1};
                    phase_d      = 1'b0;
                    state_d      = RD_Y;
                end
            end
            RD_Y: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (visible) begin
                    dy_d         = dy_new[7:0];
                    table_addr_d = {entry_q, 2'd0};
                    phase_d      = 1'b0;
                    state_d      = RD_X;
                end else begin
                    advance = 1'b1;
                end
            end
            RD_X: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    x_d          = table_data[8:0];
                    table_addr_d = {entry_q, 2'd2};
                    phase_d      = 1'b0;
                    state_d      = RD_CODE;
                end
            end
            RD_CODE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    code_d  = table_data;
                    tile_d  = 4'd0;
                    wcnt_d  = 2'd0;
                    phase_d = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                mem_we = 1'b1;
                case (wcnt_q)
                    2'd0:    mem_wdata = tile_code;
                    2'd1:    mem_wdata = {vsub, hflip_q, 2'b00, tile_x};
                    2'd2:    mem_wdata = {11'd0, pal_q};
                    default: mem_wdata = 16'd0;
                endcase
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) begin
                    wr_ptr_d = wr_ptr_q + (LW+1)'(1);
                    if (&wr_ptr_q[LW-1:0]) begin
                        state_d = IDLE;
                    end else if (tile_q == nx_q) begin
                        advance = 1'b1;
                    end else begin
                        tile_d = tile_q + 4'd1;
                    end
                end
            end
            TERM: begin
                wcnt_d    = wcnt_q + 2'd1;
                mem_we    = (wcnt_q == 2'd2);
                mem_wdata = 16'hFFFF;
                if (wcnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                mem_we    = !wr_ptr_q[LW];
                mem_waddr = {bank_q, wr_ptr_q[LW-1:0], 2'd2};
                mem_wdata = 16'hFFFF;
                bank_d    = vrender_q[0];
                wr_ptr_d  = '0;
                state_d   = INIT;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (entry_q == 8'd0) begin
                wcnt_d  = 2'd0;
                state_d = TERM;
            end else begin
                entry_d      = entry_q - 8'd1;
                table_addr_d = {entry_q - 8'd1, 2'd3};
                phase_d      = 1'b0;
                state_d      = RD_ATTR;
            end
        end

        // A restart closes the old list where it stands before switching banks.
        if (start && state_q != IDLE) begin
            vrender_d = vrender;
            bank_d    = bank_q;
            wr_ptr_d  = wr_ptr_q;
            state_d   = ABORT;
        end

        busy_d     = (state_d != IDLE);
        buf_data_d = list_mem[buf_addr];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            entry_q      <= 8'd0;
            pal_q        <= 5'd0;
            hflip_q      <= 1'b0;
            vflip_q      <= 1'b0;
            nx_q         <= 4'd0;
            ny_q         <= 4'd0;
            dy_q         <= 8'd0;
            x_q          <= 9'd0;
            code_q       <= 16'd0;
            tile_q       <= 4'd0;
            wcnt_q       <= 2'd0;
            wr_ptr_q     <= '0;
            bank_q       <= 1'b0;
            vrender_q    <= 9'd0;
            busy_q       <= 1'b0;
            table_addr_q <= 10'd0;
            buf_data_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            entry_q      <= entry_d;
            pal_q        <= pal_d;
            hflip_q      <= hflip_d;
            vflip_q      <= vflip_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            dy_q         <= dy_d;
            x_q          <= x_d;
            code_q       <= code_d;
            tile_q       <= tile_d;
            wcnt_q       <= wcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            bank_q       <= bank_d;
            vrender_q    <= vrender_d;
            busy_q       <= busy_d;
            table_addr_q <= table_addr_d;
            buf_data_q   <= buf_data_d;
        end
    end

    // NOTE: the list RAM has no reset; a terminator or the tile count always bounds
    // what the drawer reads, so stale contents are harmless and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            list_mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
